// File: rtl/lsu_obi_master_if.sv
// rtl/lsu_obi_master_if.sv - data memory request/grant/response bus
interface lsu_obi_master_if;
    logic        data_req;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata
    );
endinterface

// File: rtl/lsu_obi_master.sv
// rtl/lsu_obi_master.sv - load-store unit driving the data memory handshake
module lsu_obi_master #(
    parameter bit WORD_ADDR   = 1'b1,
    parameter int GNT_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_type,
    input  logic              lsu_sign_ext,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_rvalid,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_err,
    lsu_obi_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        type_q, type_d;
    logic              sext_q, sext_d;
    logic [1:0]        off_q, off_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic              dwe_q, dwe_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              misaligned;
    logic              timeout_hit;

    function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] typ,
                                                input logic sx, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (typ)
            2'b00:   extend_load = {{24{sx & b[7]}}, b};
            2'b01:   extend_load = {{16{sx & h[15]}}, h};
            default: extend_load = w;
        endcase
    endfunction

    assign misaligned = (lsu_type == 2'b11)
                      | ((lsu_type == 2'b01) & lsu_addr[0])
                      | ((lsu_type == 2'b10) & (lsu_addr[1:0] != 2'b00));

    // The timeout fires on the GNT_TIMEOUT-th cycle spent waiting for a grant.
    assign timeout_hit = (GNT_TIMEOUT != 0) && (cnt_q == TO_W'(GNT_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        type_d   = type_q;
        sext_d   = sext_q;
        off_d    = off_q;
        req_d    = req_q;
        addr_d   = addr_q;
        dwe_d    = dwe_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = lsu_we;
                        type_d  = lsu_type;
                        sext_d  = lsu_sign_ext;
                        off_d   = lsu_addr[1:0];
                        req_d   = 1'b1;
                        addr_d  = WORD_ADDR ? {2'b00, lsu_addr[31:2]} : {lsu_addr[31:2], 2'b00};
                        dwe_d   = lsu_we;
                        cnt_d   = '0;
                        state_d = WAIT_GNT;
                        case (lsu_type)
                            2'b00: begin
                                be_d    = 4'b0001 << lsu_addr[1:0];
                                wdata_d = {4{lsu_wdata[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << lsu_addr[1:0];
                                wdata_d = {2{lsu_wdata[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = lsu_wdata;
                            end
                        endcase
                    end
                end
            end
            WAIT_GNT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.data_gnt) begin
                    req_d = 1'b0;
                    if (bus.data_rvalid) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        if (!we_q) begin
                            rvalid_d = 1'b1;
                            rdata_d  = extend_load(bus.data_rdata, type_q, sext_q, off_q);
                        end
                    end else begin
                        state_d = WAIT_RVALID;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_RVALID: begin
                if (bus.data_rvalid) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (!we_q) begin
                        rvalid_d = 1'b1;
                        rdata_d  = extend_load(bus.data_rdata, type_q, sext_q, off_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            type_q   <= 2'b00;
            sext_q   <= 1'b0;
            off_q    <= 2'b00;
            req_q    <= 1'b0;
            addr_q   <= '0;
            dwe_q    <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            type_q   <= type_d;
            sext_q   <= sext_d;
            off_q    <= off_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            dwe_q    <= dwe_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.data_req   = req_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_we    = dwe_q;
    assign bus.data_be    = be_q;
    assign bus.data_wdata = wdata_q;
    assign lsu_busy       = busy_q;
    assign lsu_rvalid     = rvalid_q;
    assign lsu_rdata      = rdata_q;
    assign lsu_done       = done_q;
    assign lsu_err        = err_q;
endmodule

// File: doc/lsu_obi_master.md
Name: lsu_obi_master

Overview:
Load-store unit between the execute stage and data memory. Accepts one byte/halfword/word load or store per transaction from the core. Drives the data_req/data_gnt/data_rvalid memory handshake with byte enables and replicated store data. Returns the aligned, sign- or zero-extended load result. Misaligned accesses and grant timeouts are reported as one-cycle error pulses.

Parameters:
WORD_ADDR, 1, 1: data_addr = {2'b00, addr[31:2]} (word index); 0: data_addr = {addr[31:2], 2'b00}
GNT_TIMEOUT, 16, max cycles in WAIT_GNT before abort; 0 disables the timeout
TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > GNT_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
lsu_req  in  1  core request; sampled only in IDLE
lsu_we  in  1  1 = store, 0 = load
lsu_type  in  2  00 byte, 01 half, 10 word, 11 illegal
lsu_sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data, right-justified
lsu_busy  out  1  state != IDLE
lsu_rvalid  out  1  one-cycle pulse: load data valid on lsu_rdata
lsu_rdata  out  32  extended load result; held until the next load completes
lsu_done  out  1  one-cycle pulse at completion of any load or store
lsu_err  out  1  one-cycle pulse: misaligned/illegal access or grant timeout
data_req  out  1  memory request
data_addr  out  32  memory address, per WORD_ADDR
data_we  out  1  memory write enable
data_be  out  4  byte enables
data_wdata  out  32  replicated store data
data_gnt  in  1  memory grant
data_rvalid  in  1  memory response valid
data_rdata  in  32  memory read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0. All outputs 0, including lsu_rdata, data_addr, data_be and data_wdata. Any in-flight transaction is dropped with no done or err pulse.
- All outputs are registered.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, lsu_req=1, access aligned:
  - Latch we, type, sign_ext, addr[1:0].
  - Drive data_addr, data_we, data_be and data_wdata.
  - Set data_req=1 and go to WAIT_GNT on the same edge.
- IDLE, lsu_req=1, access misaligned: pulse lsu_err next cycle, stay in IDLE, data_req stays 0. Misaligned means any of:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - type=11
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- WAIT_GNT:
  - data_req and payload held stable; timeout counter increments each cycle.
  - data_gnt=1 and data_rvalid=1 in the same cycle: complete immediately (see completion).
  - data_gnt=1 alone: data_req <= 0, go to WAIT_RVALID.
  - Counter reaches GNT_TIMEOUT with no grant: data_req <= 0, pulse lsu_err, go to IDLE; no done pulse.
- WAIT_RVALID: on data_rvalid=1, complete. No timeout in this state.
- data_rvalid is ignored in IDLE, and in WAIT_GNT unless data_gnt is also 1. Stale or sticky rvalid levels therefore never complete a transaction.
- Completion:
  - data_req <= 0; pulse lsu_done; return to IDLE.
  - Load: lsu_rdata <= extended lane selected by the latched offset, and lsu_rvalid pulses with lsu_done.
  - Byte lane: data_rdata[8*off +: 8]. Half lane: off[1] ? [31:16] : [15:0].
  - Extension is sign or zero per the latched sign_ext; word is passed through.
  - Store: lsu_rdata unchanged, lsu_rvalid=0.
- Latency, memory granting the cycle after the request:
  - edge 0: request accepted, data_req high
  - edge 2: completion registered
  - done/rvalid visible for the cycle after edge 2
  - Minimum 3 cycles from lsu_req to the next IDLE acceptance.
- lsu_req while busy is ignored. The core must stall on lsu_busy and hold or re-present the request.
- Back-to-back: a request is accepted in IDLE on the cycle after lsu_done.
- Throughput is one transaction in flight; no pipelining.

Test Plan:
1. Store word 0xDEADBEEF to addr 0x10 (WORD_ADDR=1), then load word from 0x10 -> data_addr=0x4, data_be=4'b1111, data_we=1; the load returns lsu_rdata=0xDEADBEEF with lsu_rvalid and lsu_done high for one cycle.
2. Memory word 0x80FF1234:
   - lb addr 0x13 -> 0xFFFFFF80
   - lbu addr 0x13 -> 0x00000080
   - lh addr 0x12 -> 0xFFFF80FF
   - lhu addr 0x10 -> 0x00001234
3. sb 0xA5 to addr 0x21 -> data_be=4'b0010, data_wdata=0xA5A5A5A5. sh 0x1234 to addr 0x22 -> data_be=4'b1100, data_wdata=0x12341234.
4. lw addr 0x06, lh addr 0x03, type=11 -> lsu_err pulses once each, data_req never rises, lsu_done stays 0.
5. Grant delays and timeout:
   - Grant withheld 3 cycles -> data_req held stable 3 cycles, completion on the following rvalid.
   - Grant never given with GNT_TIMEOUT=16 -> lsu_err pulse after 16 WAIT_GNT cycles, then IDLE with data_req=0.
6. Assert rst_n=0 while in WAIT_RVALID; rvalid arrives after release -> all outputs 0 and state IDLE, no lsu_done or lsu_rvalid pulse; the next request proceeds normally.
